// File: rtl/reg_addr_track_fwd.sv
// reg_addr_track_fwd: tracks destination register and write/load flags
// through the ID/EX, EX/MEM and MEM/WB pipeline registers. It also produces
// registered EX operand forwarding selects and a combinational load-use stall.
// Optional feature macro: LOAD_USE_DETECT_EN. When it is undefined, no
// load-use stall is generated, and software must separate a load from its
// consumer with a NOP.
module reg_addr_track_fwd #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic [ADDR_W-1:0] id_rb,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              load_use_stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [ADDR_W-1:0] mem_rd,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              ex_regwrite,
    output logic              mem_regwrite,
    output logic              wb_regwrite,
    output logic              ex_memread
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic       bubble;
    logic [1:0] fa_d, fb_d;

`ifdef LOAD_USE_DETECT_EN
    // A load in EX whose result is needed by the ID instruction cannot be
    // forwarded in time, so hold ID for one cycle.
    assign load_use_stall = ex_memread & ex_regwrite & (ex_rd != ZR) &
                            ((ex_rd == id_rn) | (ex_rd == id_rb));
`else
    logic unused_memread;
    assign unused_memread = id_memread;
    assign load_use_stall = 1'b0;
`endif

    // A flush and a stall in the same cycle still produce only one bubble.
    assign bubble = flush | load_use_stall;

    // Operand A select. The producer now in EX will be in MEM when the
    // consumer reaches EX. A match there beats one on the older MEM producer.
    always_comb begin
        fa_d = FWD_RF;
        if (id_rn != ZR) begin
            if (ex_regwrite && ex_rd == id_rn)        fa_d = FWD_MEM;
            else if (mem_regwrite && mem_rd == id_rn) fa_d = FWD_WB;
        end
    end

    // Operand B select, same priority as operand A.
    always_comb begin
        fb_d = FWD_RF;
        if (id_rb != ZR) begin
            if (ex_regwrite && ex_rd == id_rb)        fb_d = FWD_MEM;
            else if (mem_regwrite && mem_rd == id_rb) fb_d = FWD_WB;
        end
    end

    // ID/EX register. It loads the ID instruction, or a cleared bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            fwd_a       <= FWD_RF;
            fwd_b       <= FWD_RF;
        end else if (bubble) begin
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            fwd_a       <= FWD_RF;
            fwd_b       <= FWD_RF;
        end else begin
            ex_rd       <= id_rd;
            ex_regwrite <= id_regwrite;
`ifdef LOAD_USE_DETECT_EN
            ex_memread  <= id_memread;
`else
            ex_memread  <= 1'b0;
`endif
            fwd_a       <= fa_d;
            fwd_b       <= fb_d;
        end
    end

    // EX/MEM and MEM/WB registers always advance and are never stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
        end
    end

endmodule

// File: tb/tb_reg_addr_track_fwd.sv
// Bench for reg_addr_track_fwd. The reference model keeps the last three
// instructions that entered EX, ordered by age, and derives stall and
// forwarding from the hazard rules.
module tb_reg_addr_track_fwd;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rb, id_rd;
    logic       id_regwrite, id_memread, flush;
    logic       load_use_stall;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, mem_regwrite, wb_regwrite, ex_memread;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    // age[0] = in EX, age[1] = in MEM, age[2] = in WB
    instr_t     age [3];
    logic [1:0] m_fa, m_fb;

    reg_addr_track_fwd dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rb(id_rb), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .load_use_stall(load_use_stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .ex_memread(ex_memread)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall(input logic [4:0] rn, input logic [4:0] rb);
`ifdef LOAD_USE_DETECT_EN
        return age[0].mr && age[0].rw && age[0].rd != 5'd31 &&
               (age[0].rd == rn || age[0].rd == rb);
`else
        return 1'b0;
`endif
    endfunction

    // The most recent older writer of s decides the source. One instruction
    // ahead means MEM, two ahead means WB, and X31 is never forwarded.
    function automatic logic [1:0] model_fwd(input logic [4:0] s);
        if (s == 5'd31) return 2'b00;
        if (age[0].rw && age[0].rd == s) return 2'b10;
        if (age[1].rw && age[1].rd == s) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) age[i] = '0;
        m_fa = 2'b00;
        m_fb = 2'b00;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ex_rd"},        32'(ex_rd),        32'(age[0].rd));
        chk({tag, ".ex_rw"},        32'(ex_regwrite),  32'(age[0].rw));
        chk({tag, ".ex_mr"},        32'(ex_memread),   32'(age[0].mr));
        chk({tag, ".mem_rd"},       32'(mem_rd),       32'(age[1].rd));
        chk({tag, ".mem_rw"},       32'(mem_regwrite), 32'(age[1].rw));
        chk({tag, ".wb_rd"},        32'(wb_rd),        32'(age[2].rd));
        chk({tag, ".wb_rw"},        32'(wb_regwrite),  32'(age[2].rw));
        chk({tag, ".fwd_a"},        32'(fwd_a),        32'(m_fa));
        chk({tag, ".fwd_b"},        32'(fwd_b),        32'(m_fb));
    endtask

    // Present one ID instruction for one clock. Called just after a rising edge.
    task automatic step(input string tag, input logic [4:0] rn, input logic [4:0] rb,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl);
        logic   st;
        instr_t nxt;
        logic [1:0] fa, fb;
        id_rn = rn; id_rb = rb; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
        #1;
        st = model_stall(rn, rb);
        chk({tag, ".stall"}, 32'(load_use_stall), 32'(st));
        fa = model_fwd(rn);
        fb = model_fwd(rb);
`ifdef LOAD_USE_DETECT_EN
        nxt = '{rd: rd, rw: rw, mr: mr};
`else
        nxt = '{rd: rd, rw: rw, mr: 1'b0};
`endif
        if (fl || st) begin
            nxt = '0;
            fa  = 2'b00;
            fb  = 2'b00;
        end
        age[2] = age[1];
        age[1] = age[0];
        age[0] = nxt;
        m_fa = fa;
        m_fb = fb;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
    endfunction

    initial begin
        reset = 1'b1;
        id_rn = '0; id_rb = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset.stall", 32'(load_use_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD X1, then SUB reading X1: forward from MEM
        step("add1", 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        step("sub1", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        chk("t1.fwd_a", 32'(fwd_a), 32'h2);
        chk("t1.fwd_b", 32'(fwd_b), 32'h0);
        chk("t1.mem_rd", 32'(mem_rd), 32'd1);

        // X1, unrelated instruction, then consumer on B: forward from WB
        step("w1", 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        step("nop", 5'd4, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0);
        step("c1", 5'd0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t2.fwd_b", 32'(fwd_b), 32'h1);
        chk("t2.fwd_a", 32'(fwd_a), 32'h0);

        // Two writers of X3: the nearer one wins
        step("w3a", 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        step("w3b", 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        step("c3", 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t3.fwd_a", 32'(fwd_a), 32'h2);

        // LDUR X31 followed by a reader of X31: nothing forwarded, no stall
        step("ld31", 5'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0);
        step("c31", 5'd31, 5'd31, 5'd2, 1'b0, 1'b0, 1'b0);
        chk("t4.fwd_a", 32'(fwd_a), 32'h0);

        // LDUR X5, then ADD reading X5, presented twice
        step("ld5", 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
`ifdef LOAD_USE_DETECT_EN
        id_rn = 5'd5; id_rb = 5'd0; #1;
        chk("t5.stall_hi", 32'(load_use_stall), 32'd1);
`endif
        step("add5a", 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
`ifdef LOAD_USE_DETECT_EN
        chk("t5.bubble", 32'(ex_regwrite), 32'd0);
`endif
        step("add5b", 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("t5.fwd_a", 32'(fwd_a), 32'h1);
        chk("t5.stall_lo", 32'(load_use_stall), 32'd0);

        // Flush turns the ID instruction into a bubble
        step("fl7", 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        chk("t6.ex_rw", 32'(ex_regwrite), 32'd0);
        chk("t6.ex_rd", 32'(ex_rd), 32'd0);

        // Fill the pipe, then apply an asynchronous reset mid-cycle
        step("w9a", 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        step("w9b", 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        step("w9c", 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("t7.wb_rw_pre", 32'(wb_regwrite), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd", pick(), pick(), pick(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
